vga_fb_arbiter: RTL and testbench

Shares one single-port synchronous framebuffer RAM between VGA scanout and a CPU write port. It prefetches pixels in raster order into a small show-ahead FIFO that the VGA output stage pops one pixel per visible clock. CPU writes are granted in every RAM slot the scanout does not need. The block sits between the framebuffer RAM and the VGA timing/output stage, in the pixel clock domain.

---
 rtl/vga_fb_arbiter.sv | 124 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: raster-order scanout prefetch into a show-ahead FIFO,
// with CPU pixel writes granted in every RAM slot the scanout does not need.
module vga_fb_arbiter #(
  parameter int H_SIZE     = 800,
  parameter int V_SIZE     = 600,
  parameter int COLOR_W    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = $clog2(H_SIZE * V_SIZE)
) (
  input  logic               pixelclk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               pix_pop,
  output logic [COLOR_W-1:0] pix_data,
  output logic               pix_valid,
  output logic               underrun,
  input  logic               cpu_wr_valid,
  output logic               cpu_wr_ready,
  input  logic [ADDR_W-1:0]  cpu_wr_addr,
  input  logic [COLOR_W-1:0] cpu_wr_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]   FRAME_PIX = (ADDR_W + 1)'(H_SIZE * V_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_SIZE * V_SIZE - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  fetch_addr, fetch_addr_nxt;
  logic               inflight;
  logic [COLOR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               rd_issue, push, pop, cpu_in_range;

  // Credit counts the outstanding read so a full FIFO can never be overrun.
  assign rd_issue     = (state == FETCH) && ((count + CNT_W'(inflight)) < DEPTH_C);
  assign cpu_in_range = {1'b0, cpu_wr_addr} < FRAME_PIX;
  // A read landing while frame_start flushes belongs to the old frame.
  assign push         = inflight && !frame_start;
  assign pop          = pix_pop && (count != '0) && !frame_start;

  assign pix_valid = (count != '0);
  assign pix_data  = pix_valid ? fifo_mem[rd_ptr] : '0;
  assign mem_wdata = cpu_wr_data;

  // NOTE: every output gets a default before the branches, otherwise the
  // unassigned paths infer latches.
  always_comb begin
    cpu_wr_ready = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    if (rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr;
    end else if (cpu_wr_valid) begin
      cpu_wr_ready = 1'b1;
      if (cpu_in_range) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = cpu_wr_addr;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    fetch_addr_nxt = fetch_addr;
    if (frame_start) begin
      state_nxt      = FETCH;
      fetch_addr_nxt = '0;
    end else if (rd_issue) begin
      if (fetch_addr == LAST_ADDR) begin
        state_nxt      = IDLE;
        fetch_addr_nxt = '0;
      end else begin
        fetch_addr_nxt = fetch_addr + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_addr <= '0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_addr <= fetch_addr_nxt;
      inflight   <= rd_issue && !frame_start;
      if (frame_start) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (pix_pop && (count == '0)) underrun <= 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count gates every read of it.
  always_ff @(posedge pixelclk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed + randomized bench for vga_fb_arbiter on a 4x2 frame with a
// behavioural RAM and an expected-pixel queue as the reference.
module tb_vga_fb_arbiter;
  localparam int H = 4, V = 2, CW = 12, DEPTH = 4, AW = 4, NPIX = H * V;

  logic          pixelclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_pop = 1'b0;
  logic          cpu_wr_valid = 1'b0;
  logic [AW-1:0] cpu_wr_addr = '0;
  logic [CW-1:0] cpu_wr_data = '0;
  logic [CW-1:0] mem_rdata = '0;
  logic [CW-1:0] pix_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          pix_valid, underrun, cpu_wr_ready, mem_en, mem_we;

  logic [CW-1:0] ram [NPIX];
  logic [CW-1:0] exp_q [$];
  int passed = 0;
  int total  = 0;
  int popped;

  always #5 pixelclk = ~pixelclk;

  vga_fb_arbiter #(.H_SIZE(H), .V_SIZE(V), .COLOR_W(CW), .FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .pixelclk(pixelclk), .rst_n(rst_n), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underrun(underrun),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM: read data appears the cycle after the read.
  always @(posedge pixelclk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic snapshot();
    exp_q.delete();
    for (int i = 0; i < NPIX; i++) exp_q.push_back(ram[i]);
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) ram[i] = CW'($urandom);

    // Reset values
    #12;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_underrun", underrun, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_ready_idle", cpu_wr_ready, 0);
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = AW'(8);
    #1;
    check("rst_ready_follows_valid", cpu_wr_ready, 1);
    cpu_wr_valid = 1'b0;
    rst_n = 1'b1;

    // Fill without pops: reads 0..3 in cycles 1..4
    snapshot();
    next_cycle();
    frame_start = 1'b1;
    #1;
    check("c0_no_read", mem_en, 0);
    next_cycle();
    frame_start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c <= 4) begin
        check("fill_mem_en", mem_en, 1);
        check("fill_mem_we", mem_we, 0);
        check("fill_mem_addr", mem_addr, c - 1);
      end else begin
        check("fill_done_mem_en", mem_en, 0);
        check("fill_head", pix_data, exp_q[0]);
      end
      check("fill_pix_valid", pix_valid, (c >= 3) ? 1 : 0);
      if (c < 5) next_cycle();
    end

    // CPU write into a free slot while the FIFO is full
    next_cycle();
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = AW'(5);
    cpu_wr_data  = CW'(12'hABC);
    #1;
    check("full_ready", cpu_wr_ready, 1);
    check("full_mem_we", mem_we, 1);
    check("full_mem_addr", mem_addr, 5);
    check("full_mem_wdata", mem_wdata, 12'hABC);
    next_cycle();
    cpu_wr_valid = 1'b0;

    // Whole frame, popping every cycle from cycle 3, CPU write held from cycle 1
    snapshot();
    frame_start = 1'b1;
    next_cycle();
    frame_start  = 1'b0;
    cpu_wr_valid = 1'b1;
    cpu_wr_addr  = AW'($urandom_range(0, NPIX - 1));
    cpu_wr_data  = CW'($urandom);
    for (int c = 1; c <= 12; c++) begin
      pix_pop = (c >= 3 && c <= 10);
      #1;
      if (c <= 8) begin
        check("scan_ready_stalled", cpu_wr_ready, 0);
        check("scan_read_addr", mem_addr, c - 1);
      end else begin
        check("idle_ready", cpu_wr_ready, 1);
        check("idle_cpu_we", mem_we, 1);
      end
      if (pix_pop) begin
        check("scan_pix_valid", pix_valid, 1);
        check("scan_pix_data", pix_data, exp_q.pop_front());
      end
      next_cycle();
    end
    pix_pop = 1'b0;

    // Out-of-range write in IDLE
    cpu_wr_addr = AW'(8);
    #1;
    check("oob_ready", cpu_wr_ready, 1);
    check("oob_mem_en", mem_en, 0);
    check("drained", pix_valid, 0);
    check("no_underrun_yet", underrun, 0);
    cpu_wr_valid = 1'b0;

    // Pop with FIFO empty
    pix_pop = 1'b1;
    #1;
    check("empty_pop_data", pix_data, 0);
    next_cycle();
    pix_pop = 1'b0;
    #1;
    check("underrun_set", underrun, 1);
    check("empty_pop_count", pix_valid, 0);

    // Restart mid-fetch: read of addr 2 in flight, two entries held
    snapshot();
    next_cycle();
    frame_start = 1'b1;
    next_cycle();
    frame_start = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    frame_start = 1'b1;
    #1;
    check("pre_flush_valid", pix_valid, 1);
    check("pre_flush_addr", mem_addr, 3);
    next_cycle();
    frame_start = 1'b0;
    #1;
    check("flush_empty", pix_valid, 0);
    check("restart_addr", mem_addr, 0);
    check("underrun_sticky", underrun, 1);
    next_cycle();
    check("stale_not_pushed", pix_valid, 0);
    check("restart_addr1", mem_addr, 1);
    next_cycle();
    check("restart_valid", pix_valid, 1);
    check("restart_head", pix_data, exp_q[0]);

    // Random pop pattern for the rest of this frame
    popped = 0;
    for (int n = 0; n < 300 && popped < NPIX; n++) begin
      pix_pop = pix_valid && ($urandom_range(0, 2) != 0);
      #1;
      if (pix_pop) begin
        check("rand_pix_data", pix_data, exp_q.pop_front());
        popped++;
      end
      next_cycle();
    end
    pix_pop = 1'b0;
    #1;
    check("rand_all_popped", popped, NPIX);
    check("rand_end_empty", pix_valid, 0);
    check("rand_end_idle", mem_en, 0);

    // Asynchronous reset in the middle of a fetch
    next_cycle();
    frame_start = 1'b1;
    next_cycle();
    frame_start = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", pix_valid, 0);
    check("async_rst_data", pix_data, 0);
    check("async_rst_underrun", underrun, 0);
    check("async_rst_mem_en", mem_en, 0);
    check("async_rst_mem_we", mem_we, 0);
    cpu_wr_valid = 1'b1;
    #1;
    check("async_rst_ready", cpu_wr_ready, 1);
    cpu_wr_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
